// File: rtl/button_event_arbiter_pkg.sv
// Shared FSM encodings and default sizing for the button event arbiter.
package button_event_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SERVE    = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   localparam int DEFAULT_N_CH    = 4;
   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/button_event_arbiter_edge_sync_capture.sv
// Per-channel 2-flop synchronizer followed by a registered rising-edge detector.
module edge_sync_capture (
   input  logic clk,
   input  logic reset,
   input  logic evt_raw,
   output logic evt_pulse
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= evt_raw;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign evt_pulse = sync & ~sync_d;

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter granting one shared resource to captured asynchronous events.
// Optional sticky overrun flags are built when BUTTON_EVENT_ARBITER_OVERRUN_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a pending channel; grants on the same edge it finds one
// SERVE    | svc_req high, waiting for svc_done or the wait counter to reach TIMEOUT
// COOLDOWN | one forced idle cycle between grants
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int N_CH    = DEFAULT_N_CH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         evt_in,
   input  logic                    svc_done,
   output logic                    svc_req,
   output logic [$clog2(N_CH)-1:0] svc_ch,
   output logic [N_CH-1:0]         pending,
   output logic                    timeout_err
`ifdef BUTTON_EVENT_ARBITER_OVERRUN_EN
   ,output logic [N_CH-1:0]        overrun
`endif
);

   localparam int CW = $clog2(N_CH);

   state_t          state_q, state_d;
   logic [N_CH-1:0] evt_pulse;
   logic [N_CH-1:0] pending_q, pending_d;
   logic [N_CH-1:0] grant_clr;
   logic [CW-1:0]   ch_q, ch_d;
   logic [CW-1:0]   last_q, last_d;
   logic [CW-1:0]   sel;
   logic            sel_found;
   logic [15:0]     wait_q, wait_d;
   logic            req_q, req_d;
   logic            to_q, to_d;

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      edge_sync_capture u_sync (
         .clk       (clk),
         .reset     (reset),
         .evt_raw   (evt_in[g]),
         .evt_pulse (evt_pulse[g])
      );
   end

   // First pending channel searching upward from last_grant+1, wrapping.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int i = 1; i <= N_CH; i++) begin
         logic [CW-1:0] idx;
         idx = CW'((int'(last_q) + i) % N_CH);
         if (!sel_found && pending_q[idx]) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      last_d    = last_q;
      wait_d    = wait_q;
      req_d     = req_q;
      to_d      = 1'b0;
      grant_clr = '0;
      case (state_q)
         IDLE: begin
            req_d = 1'b0;
            if (sel_found) begin
               grant_clr[sel] = 1'b1;
               ch_d           = sel;
               req_d          = 1'b1;
               wait_d         = '0;
               state_d        = SERVE;
            end
         end
         SERVE: begin
            if (svc_done) begin
               last_d  = ch_q;
               req_d   = 1'b0;
               state_d = COOLDOWN;
            end else if (wait_q == 16'(TIMEOUT - 1)) begin
               to_d    = 1'b1;
               last_d  = ch_q;
               req_d   = 1'b0;
               state_d = COOLDOWN;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         COOLDOWN: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
      // A new event in the grant cycle keeps the channel pending.
      pending_d = (pending_q & ~grant_clr) | evt_pulse;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         ch_q      <= '0;
         last_q    <= CW'(N_CH - 1);
         wait_q    <= '0;
         req_q     <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ch_q      <= ch_d;
         last_q    <= last_d;
         wait_q    <= wait_d;
         req_q     <= req_d;
         to_q      <= to_d;
      end
   end

`ifdef BUTTON_EVENT_ARBITER_OVERRUN_EN
   logic [N_CH-1:0] overrun_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_q <= '0;
      end else begin
         overrun_q <= overrun_q | (evt_pulse & pending_q & ~grant_clr);
      end
   end

   assign overrun = overrun_q;
`else
   // Repeated events on a pending channel merge silently.
`endif

   assign svc_req     = req_q;
   assign svc_ch      = req_q ? ch_q : '0;
   assign pending     = pending_q;
   assign timeout_err = to_q;

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of asynchronous event channels (2..8).
REQ-002 Parameter TIMEOUT, default 255: maximum cycles SERVE waits for svc_done (1..65535).
REQ-003 Port clk  input  1: system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: reset, asynchronous, active-high; clock clk.
REQ-005 Port evt_in  input  N_CH: raw asynchronous level inputs, one per channel.
REQ-006 Port svc_done  input  1: one-cycle pulse from the shared resource; marks the current service complete.
REQ-007 Port svc_req  output  1: high while a channel is granted the shared resource.
REQ-008 Port svc_ch  output  clog2(N_CH): index of the granted channel; valid while svc_req=1, otherwise 0.
REQ-009 Port pending  output  N_CH: per-channel captured-but-unserved event flags.
REQ-010 Port timeout_err  output  1: one-cycle pulse when a service is abandoned.

Function
REQ-011 Each evt_in[i] SHALL pass a 2-flop synchronizer, then a registered rising-edge detector; one rise yields exactly one single-cycle event.
REQ-012 Latency: evt_in[i] first sampled high at edge k -> pending[i]=1 after edge k+2.
REQ-013 An event SHALL set pending[i]; an event on an already-pending channel merges (no second service).
REQ-014 FSM states SHALL be IDLE, SERVE, COOLDOWN.
REQ-015 IDLE: if pending!=0, select the first set bit searching upward (with wrap-around) from last_grant+1; clear that pending bit; load svc_ch; assert svc_req; go SERVE (same edge).
REQ-016 IDLE with pending=0: stay in IDLE; svc_req=0.
REQ-017 SERVE: svc_req=1; svc_done=1 -> update last_grant to svc_ch, deassert svc_req, go COOLDOWN.
REQ-018 SERVE: wait counter SHALL increment each cycle; on reaching TIMEOUT without svc_done -> pulse timeout_err, update last_grant, deassert svc_req, go COOLDOWN.
REQ-019 COOLDOWN SHALL last exactly one cycle, svc_req=0, then IDLE; guarantees one idle cycle between grants.
REQ-020 svc_done outside SERVE SHALL be ignored.
REQ-021 An event on channel i in the same cycle its pending bit is cleared by grant SHALL leave pending[i]=1 (set wins).
REQ-022 svc_done and timeout in the same cycle: done wins, no timeout_err.

Reset
REQ-023 Reset SHALL asynchronously force: state IDLE, svc_req=0, svc_ch=0, pending=0, timeout_err=0, synchronizer/edge flops=0, wait counter=0.
REQ-024 last_grant SHALL reset to N_CH-1 so channel 0 wins the first arbitration.
REQ-025 Reset during SERVE SHALL drop svc_req immediately; the in-flight service is lost, not re-queued.
REQ-026 After reset release, an evt_in already high SHALL produce one event (flops reset low).

Configuration
REQ-027 Macro BUTTON_EVENT_ARBITER_OVERRUN_EN, when defined, SHALL add output overrun [N_CH]: sticky bit set when an event arrives while pending[i]=1 (excluding REQ-021 case); cleared only by reset.
REQ-028 Without the macro, no overrun port or logic SHALL exist; merge behaviour (REQ-013) is unchanged.

Structure
REQ-029 A shared package SHALL hold FSM state encodings (IDLE=2'd0, SERVE=2'd1, COOLDOWN=2'd2) and the default N_CH/TIMEOUT constants.
REQ-030 Per-channel sync-plus-edge-detect SHALL be a sub-module edge_sync_capture, instantiated N_CH times.
REQ-031 Round-robin selection SHALL be combinational in the top; all outputs registered except svc_ch decode from registered index.

Verification
REQ-032 Reset, raise evt_in=4'b0001 -> pending=0001 after 2 edges, next edge svc_req=1, svc_ch=0, pending=0000.
REQ-033 evt_in=4'b1111 simultaneously, svc_done 3 cycles after each grant -> grants 0,1,2,3 in order, each separated by one COOLDOWN cycle.
REQ-034 last_grant=2, pending=1011 -> next grant channel 3, then 0, then 1.
REQ-035 TIMEOUT=10, grant channel 1, no svc_done -> timeout_err pulse at 10th SERVE cycle, svc_req low, COOLDOWN then IDLE.
REQ-036 With OVERRUN_EN: toggle evt_in[2] twice while pending[2]=1 -> overrun=0100, exactly one service on channel 2.
REQ-037 Assert reset during SERVE -> svc_req=0 asynchronously, pending=0, no timeout_err; first post-reset grant is channel 0.
